// File: rtl/piso_pkg.sv
// Shared encodings and sizing helpers for the PISO serialiser.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit index: reset to 0 on load/clear, otherwise steps once per frame bit.
// o_last flags the final bit of the frame (index FRAME_LEN-1).
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(frame_len(WIDTH) - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && !o_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out front end: takes a word over valid/ready and shifts it out one bit per clk.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_sout_valid;
`ifdef PISO_PARITY_EN
  logic             r_parity;
`endif

  logic [CW-1:0]    w_cnt;
  logic             w_last;
  logic             w_data_last;
  logic             w_accept;
  logic             w_din_first;
  logic [WIDTH-1:0] w_din_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shift_rest;

  // Ready also in the final frame bit so a new word follows with no bubble.
  assign din_ready   = !rst && ((r_state == ST_IDLE) || w_last);
  assign w_accept    = din_valid && din_ready;
  assign w_data_last = (w_cnt == CW'(WIDTH - 1));

  assign w_din_first  = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign w_din_rest   = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
  assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shift_rest = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_clear (w_last && !w_accept),
    .i_inc   ((r_state != ST_IDLE) && !w_accept),
    .o_cnt   (w_cnt),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else if (w_accept) begin
      // First bit goes straight to sout; the shift register keeps the remainder aligned.
      r_state      <= ST_SHIFT;
      r_shift      <= w_din_rest;
      r_sout       <= w_din_first;
      r_sout_valid <= 1'b1;
`ifdef PISO_PARITY_EN
      r_parity     <= ^din;
`endif
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (w_data_last) begin
`ifdef PISO_PARITY_EN
            r_state <= ST_PARITY;
            r_sout  <= r_parity;
`else
            r_state      <= ST_IDLE;
            r_sout_valid <= 1'b0;
`endif
          end else begin
            r_shift <= w_shift_rest;
            r_sout  <= w_next_bit;
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: begin
          r_state      <= ST_IDLE;
          r_sout_valid <= 1'b0;
        end
`endif
        default: begin
          r_state      <= ST_IDLE;
          r_sout_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign frame_done = (r_state != ST_IDLE) && w_last;

endmodule
